// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the divide-ratio controller.
//   state_e         : controller FSM states
//   CW_DEF          : default ratio/counter width
//   RESET_RATIO_DEF : default divide ratio after reset
//   ratio_ok()      : true for an even ratio of at least 2
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PEND  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam int unsigned CW_DEF          = 8;
  localparam int unsigned RESET_RATIO_DEF = 6;

  // Callers zero-extend the ratio to 32 bits so one function serves any CW.
  function automatic logic ratio_ok(input logic [31:0] ratio);
    return (ratio[0] == 1'b0) && (ratio >= 32'd2);
  endfunction

endpackage

// File: rtl/div_ratio_ctrl_if.sv
// Control/status bundle of the divide-ratio controller.
//   master : run request and ratio-request side (drives en, cfg_valid, cfg_ratio)
//   slave  : controller side (drives cfg_ready, cfg_err, clk_div, period_tick,
//            ratio_cur, active)
interface div_ratio_ctrl_if #(
  parameter int unsigned CW = 8
) ();

  logic          en;
  logic          cfg_valid;
  logic [CW-1:0] cfg_ratio;
  logic          cfg_ready;
  logic          cfg_err;
  logic          clk_div;
  logic          period_tick;
  logic [CW-1:0] ratio_cur;
  logic          active;

  modport master (
    output en, cfg_valid, cfg_ratio,
    input  cfg_ready, cfg_err, clk_div, period_tick, ratio_cur, active
  );

  modport slave (
    input  en, cfg_valid, cfg_ratio,
    output cfg_ready, cfg_err, clk_div, period_tick, ratio_cur, active
  );

endinterface

// File: rtl/div_core.sv
// Counter/toggle datapath: counts 1..half, reloads and toggles clk_div at half.
//   clk, reset : clock, async active-low reset
//   half       : half period in clk cycles (ratio >> 1)
//   run        : 0 holds count=1 and clk_div=0
//   reload     : forces count back to 1 on the next edge
//   clk_div    : registered divided clock
//   boundary   : this cycle ends a high phase (clk_div about to fall)
//   rise       : this cycle ends a low phase (clk_div about to rise)
module div_core #(
  parameter int unsigned HW = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [HW-1:0] half,
  input  logic          run,
  input  logic          reload,
  output logic          clk_div,
  output logic          boundary,
  output logic          rise
);

  logic [HW-1:0] count;
  logic          at_half;

  assign at_half  = (count == half);
  assign boundary = run && at_half && clk_div;
  assign rise     = run && at_half && !clk_div;

  // Phase counter and output toggle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= HW'(1);
      clk_div <= 1'b0;
    end else if (!run) begin
      count   <= HW'(1);
      clk_div <= 1'b0;
    end else begin
      if (at_half) clk_div <= ~clk_div;
      if (at_half || reload) count <= HW'(1);
      else                   count <= count + HW'(1);
    end
  end

endmodule

// File: rtl/div_ratio_ctrl.sv
// Divide-ratio controller: run/stop FSM, ratio handshake and ratio registers
// around a div_core datapath. Ratio changes take effect only at period ends.
//   clk, reset : clock, async active-low reset
//   bus        : div_ratio_ctrl_if slave (en, cfg_*, clk_div, period_tick,
//                ratio_cur, active)
module div_ratio_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned CW          = CW_DEF,
  parameter int unsigned RESET_RATIO = RESET_RATIO_DEF
) (
  input  logic           clk,
  input  logic           reset,
  div_ratio_ctrl_if.slave bus
);

  localparam int unsigned HW = CW - 1;

  state_e        state, state_nxt;
  logic [CW-1:0] ratio_cur_q, ratio_cur_nxt;
  logic [CW-1:0] ratio_pend, ratio_pend_nxt;
  logic          cfg_ready_q, cfg_err_q, period_tick_q, active_q;
  logic          cfg_err_nxt, apply;
  logic          accept, ratio_valid, has_pend;
  logic          boundary, rise, clk_div;

  assign accept      = bus.cfg_valid && cfg_ready_q;
  assign ratio_valid = ratio_ok(32'(bus.cfg_ratio));
  // Zero marks "no pending ratio" since zero is never a valid ratio.
  assign has_pend    = (ratio_pend != '0);

  div_core #(.HW(HW)) u_core (
    .clk      (clk),
    .reset    (reset),
    .half     (HW'(ratio_cur_q >> 1)),
    .run      (state != ST_IDLE),
    .reload   (apply),
    .clk_div  (clk_div),
    .boundary (boundary),
    .rise     (rise)
  );

  // Next-state, handshake and ratio update.
  always_comb begin
    state_nxt      = state;
    ratio_cur_nxt  = ratio_cur_q;
    ratio_pend_nxt = ratio_pend;
    cfg_err_nxt    = accept && !ratio_valid;
    apply          = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && ratio_valid) ratio_cur_nxt = bus.cfg_ratio;
        if (bus.en) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (accept && ratio_valid) begin
          ratio_pend_nxt = bus.cfg_ratio;
          state_nxt      = bus.en ? ST_PEND : ST_DRAIN;
        end else if (!bus.en) begin
          // Dropping en exactly at a period end stops without an extra period.
          state_nxt = boundary ? ST_IDLE : ST_DRAIN;
        end
      end
      ST_PEND: begin
        if (boundary) begin
          apply     = 1'b1;
          state_nxt = bus.en ? ST_RUN : ST_IDLE;
        end else if (!bus.en) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (boundary) begin
          apply     = has_pend;
          state_nxt = bus.en ? ST_RUN : ST_IDLE;
        end else if (bus.en) begin
          state_nxt = has_pend ? ST_PEND : ST_RUN;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (apply) begin
      ratio_cur_nxt  = ratio_pend;
      ratio_pend_nxt = '0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      ratio_cur_q   <= CW'(RESET_RATIO);
      ratio_pend    <= '0;
      cfg_ready_q   <= 1'b1;
      cfg_err_q     <= 1'b0;
      period_tick_q <= 1'b0;
      active_q      <= 1'b0;
    end else begin
      state         <= state_nxt;
      ratio_cur_q   <= ratio_cur_nxt;
      ratio_pend    <= ratio_pend_nxt;
      cfg_ready_q   <= (state_nxt != ST_PEND) && (state_nxt != ST_DRAIN);
      cfg_err_q     <= cfg_err_nxt;
      period_tick_q <= rise;
      active_q      <= (state_nxt == ST_RUN) || (state_nxt == ST_PEND);
    end
  end

  assign bus.cfg_ready   = cfg_ready_q;
  assign bus.cfg_err     = cfg_err_q;
  assign bus.clk_div     = clk_div;
  assign bus.period_tick = period_tick_q;
  assign bus.ratio_cur   = ratio_cur_q;
  assign bus.active      = active_q;

endmodule
